// File: rtl/abc_stim_pkg.sv
// Shared types and constants for the a/b/c stimulus sequencer.
package abc_stim_pkg;
    typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;
    localparam int NUM_PATTERNS = 8;
    localparam int IDX_W        = $clog2(NUM_PATTERNS);
endpackage

// File: rtl/abc_stim_seq_hold_counter.sv
// Per-pattern hold counter: counts 0..HOLD_CYCLES-1 while enabled, flags the last cycle.
module hold_counter
    import abc_stim_pkg::*;
#(
    parameter int HOLD_CYCLES = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic last
);
    localparam int            CW       = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(HOLD_CYCLES - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            if (r_count == LAST_CNT) r_count <= '0;
            else                     r_count <= r_count + 1'b1;
        end
    end

    assign last = (r_count == LAST_CNT);
endmodule

// File: rtl/abc_stim_seq.sv
// Steps {a,b,c} through 000..111, holding each pattern HOLD_CYCLES cycles,
// with a settle strobe on the last hold cycle for a downstream capture stage.
//
// state | meaning
// IDLE  | waiting for start, idx 000, nothing driven live
// DRIVE | patterns live, hold counter running
// DONE  | pass complete, idx holds 111, done sticky until start/stop/rst
module abc_stim_seq
    import abc_stim_pkg::*;
#(
    parameter int HOLD_CYCLES = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       loop_en,
    input  logic       pause,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic [2:0] idx,
    output logic       valid,
    output logic       sample,
    output logic       busy,
    output logic       done
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PATTERNS - 1);

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic             r_active;
    logic             r_done;
    logic             w_last;
    logic             w_clear;
    logic             w_enable;

    // Counter sits at zero outside DRIVE so every pass starts from a fresh hold.
    assign w_clear  = (r_state != DRIVE) || stop;
    assign w_enable = (r_state == DRIVE) && !pause;

    hold_counter #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold (
        .clk    (clk),
        .rst    (rst),
        .clear  (w_clear),
        .enable (w_enable),
        .last   (w_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_active <= 1'b0;
            r_done   <= 1'b0;
        end else if (stop) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_active <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state  <= DRIVE;
                        r_idx    <= '0;
                        r_active <= 1'b1;
                        r_done   <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (w_last && !pause) begin
                        if (r_idx != LAST_IDX) begin
                            r_idx <= r_idx + 1'b1;
                        end else if (loop_en) begin
                            r_idx <= '0;
                        end else begin
                            r_state  <= DONE;
                            r_active <= 1'b0;
                            r_done   <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_idx    <= '0;
                    r_active <= 1'b0;
                    r_done   <= 1'b0;
                end
            endcase
        end
    end

    assign {a, b, c} = r_idx;
    assign idx       = r_idx;
    assign valid     = r_active;
    assign busy      = r_active;
    assign done      = r_done;
    assign sample    = (r_state == DRIVE) && w_last && !pause;
endmodule

// File: tb/tb_abc_stim_seq.sv
// Directed bench for abc_stim_seq: a HOLD_CYCLES=10 build and a HOLD_CYCLES=1 build.
module tb_abc_stim_seq;
    logic       clk = 1'b0;
    logic       rst, start, start_1, stop, loop_en, pause;
    logic       a, b, c, valid, sample, busy, done;
    logic [2:0] idx;
    logic       a_1, b_1, c_1, valid_1, sample_1, busy_1, done_1;
    logic [2:0] idx_1;
    int         n_checks = 0;
    int         n_fail   = 0;

    always #5 clk = ~clk;

    abc_stim_seq #(.HOLD_CYCLES(10)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en), .pause(pause),
        .a(a), .b(b), .c(c), .idx(idx), .valid(valid), .sample(sample), .busy(busy), .done(done)
    );

    abc_stim_seq #(.HOLD_CYCLES(1)) dut_1 (
        .clk(clk), .rst(rst), .start(start_1), .stop(stop), .loop_en(loop_en), .pause(pause),
        .a(a_1), .b(b_1), .c(c_1), .idx(idx_1), .valid(valid_1), .sample(sample_1),
        .busy(busy_1), .done(done_1)
    );

    task automatic start_pulse();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            #1;
            n_checks++;
            if ({a, b, c, idx, valid, sample, busy, done} !== 10'b0) begin
                n_fail++;
                $display("FAIL reset_idle cycle %0d: outputs=%b required=0", k,
                         {a, b, c, idx, valid, sample, busy, done});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_single_pass();
        int pulses;
        pulses = 0;
        start_pulse();
        for (int k = 0; k < 80; k++) begin
            #1;
            n_checks++;
            if (idx !== 3'(k / 10) || {a, b, c} !== 3'(k / 10) || valid !== 1'b1 || done !== 1'b0
                || sample !== (k % 10 == 9)) begin
                n_fail++;
                $display("FAIL single_pass k=%0d: idx=%0d abc=%b valid=%b sample=%b done=%b required idx=%0d sample=%b",
                         k, idx, {a, b, c}, valid, sample, done, k / 10, (k % 10 == 9));
            end
            if (sample === 1'b1) pulses++;
            @(negedge clk);
        end
        #1;
        n_checks++;
        if (done !== 1'b1 || {a, b, c} !== 3'b111 || idx !== 3'd7 || valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_pass_done: done=%b abc=%b idx=%0d valid=%b busy=%b required done=1 abc=111 valid=0 busy=0",
                     done, {a, b, c}, idx, valid, busy);
        end
        n_checks++;
        if (pulses != 8) begin
            n_fail++;
            $display("FAIL single_pass_pulses: got %0d required 8", pulses);
        end
        repeat (5) @(negedge clk);
        #1;
        n_checks++;
        if (done !== 1'b1 || {a, b, c} !== 3'b111) begin
            n_fail++;
            $display("FAIL done_sticky: done=%b abc=%b required done=1 abc=111", done, {a, b, c});
        end
    endtask

    task automatic test_loop_stop();
        loop_en = 1'b1;
        start_pulse();
        for (int k = 0; k < 85; k++) begin
            #1;
            n_checks++;
            if (idx !== 3'((k / 10) % 8) || busy !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL loop k=%0d: idx=%0d busy=%b done=%b required idx=%0d busy=1 done=0",
                         k, idx, busy, done, (k / 10) % 8);
            end
            @(negedge clk);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        loop_en = 1'b0;
        #1;
        n_checks++;
        if (valid !== 1'b0 || idx !== 3'd0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_mid: valid=%b idx=%0d busy=%b done=%b required all 0",
                     valid, idx, busy, done);
        end
    endtask

    task automatic test_start_stop_collision();
        @(negedge clk); start = 1'b1; stop = 1'b1;
        @(negedge clk); start = 1'b0; stop = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || valid !== 1'b0 || idx !== 3'd0) begin
            n_fail++;
            $display("FAIL start_stop: busy=%b valid=%b idx=%0d required 0 0 0", busy, valid, idx);
        end
    endtask

    task automatic test_pause();
        int pulses;
        int e_idx;
        logic e_smp;
        pulses = 0;
        start_pulse();
        for (int k = 0; k < 85; k++) begin
            pause = (k >= 35 && k < 40);
            start = (k == 20);
            e_idx = (k < 35) ? k / 10 : ((k < 45) ? 3 : (k - 5) / 10);
            e_smp = (k < 35) ? (k % 10 == 9) : ((k < 40) ? 1'b0 : ((k - 5) % 10 == 9));
            #1;
            n_checks++;
            if (idx !== 3'(e_idx) || sample !== e_smp || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL pause k=%0d: idx=%0d sample=%b busy=%b required idx=%0d sample=%b busy=1",
                         k, idx, sample, busy, e_idx, e_smp);
            end
            if (sample === 1'b1) pulses++;
            @(negedge clk);
        end
        pause = 1'b0;
        start = 1'b0;
        #1;
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || pulses != 8) begin
            n_fail++;
            $display("FAIL pause_total: done=%b busy=%b pulses=%0d required done=1 busy=0 pulses=8",
                     done, busy, pulses);
        end
    endtask

    task automatic test_async_reset();
        start_pulse();
        repeat (53) @(negedge clk);
        #1;
        n_checks++;
        if (idx !== 3'd5) begin
            n_fail++;
            $display("FAIL async_pre: idx=%0d required 5", idx);
        end
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({a, b, c, idx, valid, sample, busy, done} !== 10'b0) begin
            n_fail++;
            $display("FAIL async_reset: outputs=%b required 0", {a, b, c, idx, valid, sample, busy, done});
        end
        #1 rst = 1'b0;
        start_pulse();
        #1;
        n_checks++;
        if (idx !== 3'd0 || valid !== 1'b1) begin
            n_fail++;
            $display("FAIL restart: idx=%0d valid=%b required idx=0 valid=1", idx, valid);
        end
        repeat (10) @(negedge clk);
        #1;
        n_checks++;
        if (idx !== 3'd1) begin
            n_fail++;
            $display("FAIL restart_advance: idx=%0d required 1", idx);
        end
        @(negedge clk); stop = 1'b1;
        @(negedge clk); stop = 1'b0;
    endtask

    task automatic test_hold1();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        @(negedge clk); start_1 = 1'b1;
        @(negedge clk); start_1 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            n_checks++;
            if (idx_1 !== 3'(k) || sample_1 !== 1'b1 || done_1 !== 1'b0) begin
                n_fail++;
                $display("FAIL hold1 k=%0d: idx=%0d sample=%b done=%b required idx=%0d sample=1 done=0",
                         k, idx_1, sample_1, done_1, k);
            end
            @(negedge clk);
        end
        #1;
        n_checks++;
        if (done_1 !== 1'b1 || idx_1 !== 3'd7 || sample_1 !== 1'b0 || busy_1 !== 1'b0) begin
            n_fail++;
            $display("FAIL hold1_done: done=%b idx=%0d sample=%b busy=%b required 1 7 0 0",
                     done_1, idx_1, sample_1, busy_1);
        end
    endtask

    task automatic test_pause_last();
        logic [2:0] e_idx [6] = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd2, 3'd3};
        logic       e_smp [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        @(negedge clk); start_1 = 1'b1;
        @(negedge clk); start_1 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            pause = (k == 2 || k == 3);
            #1;
            n_checks++;
            if (idx_1 !== e_idx[k] || sample_1 !== e_smp[k]) begin
                n_fail++;
                $display("FAIL pause_last k=%0d: idx=%0d sample=%b required idx=%0d sample=%b",
                         k, idx_1, sample_1, e_idx[k], e_smp[k]);
            end
            @(negedge clk);
        end
        pause = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start_1 = 1'b0; stop = 1'b0; loop_en = 1'b0; pause = 1'b0;
        test_reset();
        test_single_pass();
        test_loop_stop();
        test_start_stop_collision();
        test_pause();
        test_async_reset();
        test_hold1();
        test_pause_last();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/abc_stim_seq.md
# abc_stim_seq

- Clocked stimulus sequencer directly upstream of the 3-input combinational lab block (inputs a, b, c; outputs x, y).
- Steps a/b/c through all 8 combinations, 000 to 111, holding each for a programmable number of cycles.
- Flags when each pattern is settled so a downstream capture stage can sample x/y.
- Replaces the hand-written delay stimulus with synthesizable, board-runnable sequencing.

## Interface
- HOLD_CYCLES, default 10: cycles each pattern is held. Legal range 1..255.
- clk  input  1  rising-edge clock
- rst  input  1  reset; asynchronous, active-high
- start  input  1  begin a pass; accepted only in IDLE or DONE
- stop  input  1  synchronous abort to IDLE
- loop_en  input  1  wrap from 111 back to 000 instead of finishing
- pause  input  1  freeze current pattern and hold count
- a, b, c  output  1 each  stimulus bits; a is MSB of idx
- idx  output  3  current pattern number, equal to {a,b,c}
- valid  output  1  a/b/c carry a live pattern (state DRIVE)
- sample  output  1  one-cycle strobe on the last hold cycle of a pattern
- busy  output  1  high in DRIVE
- done  output  1  sticky pass-complete flag

## Operation
- States: IDLE, DRIVE, DONE.
- Reset (async, any time, including mid-pass) forces:
  - state IDLE, idx 000, hold count 0;
  - valid, sample, busy and done all 0.
- IDLE/DONE with start=1: next state DRIVE, idx 000, hold count 0, done cleared.
- DRIVE:
  - start is ignored.
  - If pause=0, hold count increments each cycle.
  - If pause=1, idx and hold count hold and sample is forced 0.
- Pattern advance, when hold count = HOLD_CYCLES-1 and pause=0:
  - hold count returns to 0.
  - If idx<7, idx increments.
  - If idx=7 and loop_en=1, idx wraps to 000 and the block stays in DRIVE.
  - If idx=7 and loop_en=0, next state DONE and done=1.
- loop_en is sampled only at the 111 advance point. Deasserting it mid-pass lets the current pass finish normally.
- DONE:
  - a/b/c/idx hold 111; valid=0, busy=0, done=1.
  - done stays high until start, stop or rst.
- stop=1 in any state: next state IDLE, idx 000, done 0.
- Priority: rst > stop > start > pause.
- sample = (state==DRIVE) && (hold count==HOLD_CYCLES-1) && !pause. Combinational from registered state and pause; no other outputs depend on inputs combinationally.
- Hold count width: max(1, $clog2(HOLD_CYCLES)). Comparisons use the full width; no overflow is possible.

## Timing
- Start latency:
  - Start sampled at edge N gives DRIVE, valid=1 and idx=000 visible after edge N.
  - The first sample strobe occurs in cycle N+HOLD_CYCLES.
- Per-pattern sample spacing: exactly HOLD_CYCLES cycles, extended by one cycle per paused cycle.
- Single pass with no pause:
  - 8*HOLD_CYCLES cycles in DRIVE;
  - 8 sample pulses;
  - done rises 8*HOLD_CYCLES edges after the start edge.
- HOLD_CYCLES=1: sample is high on every unpaused DRIVE cycle and idx changes every edge.
- Pause on the last hold cycle:
  - sample drops while paused;
  - it reasserts on the first unpaused cycle, followed by the advance.
- Simultaneous start and stop: stop wins; the block stays in or returns to IDLE.
- Start on the same cycle DONE is entered is not possible. Start in DONE restarts the pass one cycle later.

## Structure
- Package abc_stim_pkg holds:
  - typedef enum logic [1:0] state_t {IDLE, DRIVE, DONE};
  - localparam NUM_PATTERNS = 8.
- One natural sub-module, hold_counter:
  - parameterised HOLD_CYCLES;
  - inputs clear and enable;
  - output last (count==HOLD_CYCLES-1).
- The top level holds the FSM, the idx register and output decode, and instantiates hold_counter.

## Test plan
- Reset then idle: rst pulse, no start → all outputs 0 for 20 cycles.
- Single pass, HOLD_CYCLES=10:
  - one-cycle start → idx steps 0..7 every 10 cycles with 8 sample pulses;
  - done=1 exactly 80 edges after the start edge; a/b/c hold 111 in DONE.
- Loop and stop:
  - loop_en=1 → after 111, idx returns to 000 and busy stays 1;
  - stop mid-pattern → IDLE next cycle, idx 000, valid 0.
- Pause:
  - pause held 5 cycles during idx=011 → idx=011 lasts 15 cycles;
  - no sample while paused; total pass time is 85 cycles.
- HOLD_CYCLES=1 build → sample high 8 consecutive cycles; idx 0..7 on successive edges; done on edge 8.
- Async reset mid-pass: rst asserted between clock edges at idx=101 → outputs clear immediately; a fresh start begins again at 000.
